// File: rtl/pkt_rx_check_if.sv
// pkt_rx_check_if: upload word stream in, tagged payload and packet reports out
interface pkt_rx_check_if;
   logic        data_valid;
   logic [63:0] up_data;
   logic        pay_valid;
   logic [63:0] pay_data;
   logic [4:0]  pay_chan;
   logic        pay_last;
   logic        pkt_done;
   logic        pkt_ok;
   logic        err_head;
   logic        err_chan;
   logic        err_seq;
   logic        err_len;
   logic [31:0] good_cnt;
   logic [31:0] bad_cnt;
   modport master (
      output data_valid, up_data,
      input  pay_valid, pay_data, pay_chan, pay_last, pkt_done, pkt_ok,
      input  err_head, err_chan, err_seq, err_len, good_cnt, bad_cnt
   );
   modport slave (
      input  data_valid, up_data,
      output pay_valid, pay_data, pay_chan, pay_last, pkt_done, pkt_ok,
      output err_head, err_chan, err_seq, err_len, good_cnt, bad_cnt
   );
endinterface

// File: rtl/pkt_rx_check.sv
// pkt_rx_check: parses upload packets, checks header/channel/sequence/length, forwards payload
module pkt_rx_check #(
   parameter int          YUZHI  = 128,
   parameter logic [31:0] HEAD   = 32'hadf90c00,
   parameter int          NUM_CH = 30
) (
   input logic clk,
   input logic rst_n,
   pkt_rx_check_if.slave bus
);
   localparam int PW = $clog2(YUZHI);
   typedef enum logic [2:0] {S_HEAD, S_SEQ, S_PAY, S_TAIL, S_DROP, S_REPORT} state_t;
   state_t        state, state_n;
   logic [4:0]    chan, chan_n;
   logic [PW-1:0] cnt, cnt_n;
   logic [3:0]    flg, flg_n;
   logic          pv_n, pl_n, done_n, upd, good_inc, bad_inc;
   logic          hd_bad, ch_bad, seq_bad;
   logic [63:0]   exp_cnt [0:NUM_CH];
   assign hd_bad  = bus.up_data[63:32] != HEAD;
   assign ch_bad  = bus.up_data[31:0] == 32'd0 || bus.up_data[31:0] > 32'(NUM_CH);
   assign seq_bad = bus.up_data != exp_cnt[chan] + 64'd1;
   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= S_HEAD;
      else state <= state_n;
   // next state, error accumulation ({head,chan,seq,len}) and next output values
   always_comb begin
      state_n  = state;
      chan_n   = chan;
      cnt_n    = cnt;
      flg_n    = flg;
      pv_n     = 1'b0;
      pl_n     = 1'b0;
      done_n   = 1'b0;
      upd      = 1'b0;
      bad_inc  = 1'b0;
      case (state)
         S_HEAD: if (bus.data_valid) begin
            flg_n   = {hd_bad, ch_bad, 2'b00};
            chan_n  = bus.up_data[4:0];
            state_n = (hd_bad || ch_bad) ? S_DROP : S_SEQ;
         end
         S_SEQ: if (bus.data_valid) begin
            flg_n[1] = seq_bad;
            upd      = 1'b1;
            cnt_n    = '0;
            state_n  = S_PAY;
         end else begin
            flg_n[0] = 1'b1;
            done_n   = 1'b1;
            state_n  = S_REPORT;
         end
         S_PAY: if (bus.data_valid) begin
            pv_n    = 1'b1;
            pl_n    = cnt == PW'(YUZHI - 1);
            cnt_n   = cnt + 1'b1;
            state_n = pl_n ? S_TAIL : S_PAY;
         end else begin
            flg_n[0] = 1'b1;
            done_n   = 1'b1;
            state_n  = S_REPORT;
         end
         S_TAIL: if (bus.data_valid) begin
            flg_n[0] = 1'b1;
            state_n  = S_DROP;
         end else begin
            done_n  = 1'b1;
            state_n = S_REPORT;
         end
         S_DROP: if (!bus.data_valid) begin
            done_n  = 1'b1;
            state_n = S_REPORT;
         end
         S_REPORT: begin
            flg_n   = '0;
            bad_inc = bus.data_valid;
            state_n = S_HEAD;
         end
         default: state_n = S_HEAD;
      endcase
      good_inc = done_n && flg_n == 4'd0;
      bad_inc  = bad_inc || (done_n && flg_n != 4'd0);
   end
   // packet context: latched channel, payload counter, accumulated errors
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         chan <= '0;
         cnt  <= '0;
         flg  <= '0;
      end else begin
         chan <= chan_n;
         cnt  <= cnt_n;
         flg  <= flg_n;
      end
   // per-channel last seen count; every w1 resyncs its channel
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) for (int i = 0; i <= NUM_CH; i++) exp_cnt[i] <= '0;
      else if (upd) exp_cnt[chan] <= bus.up_data;
   // registered outputs; flags and payload fields are zero when not qualified
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         bus.pay_valid <= 1'b0;
         bus.pay_data  <= '0;
         bus.pay_chan  <= '0;
         bus.pay_last  <= 1'b0;
         bus.pkt_done  <= 1'b0;
         bus.pkt_ok    <= 1'b0;
         bus.err_head  <= 1'b0;
         bus.err_chan  <= 1'b0;
         bus.err_seq   <= 1'b0;
         bus.err_len   <= 1'b0;
         bus.good_cnt  <= '0;
         bus.bad_cnt   <= '0;
      end else begin
         bus.pay_valid <= pv_n;
         bus.pay_data  <= pv_n ? bus.up_data : '0;
         bus.pay_chan  <= pv_n ? chan : '0;
         bus.pay_last  <= pl_n;
         bus.pkt_done  <= done_n;
         bus.pkt_ok    <= good_inc;
         bus.err_head  <= done_n && flg_n[3];
         bus.err_chan  <= done_n && flg_n[2];
         bus.err_seq   <= done_n && flg_n[1];
         bus.err_len   <= done_n && flg_n[0];
         bus.good_cnt  <= bus.good_cnt + 32'(good_inc);
         bus.bad_cnt   <= bus.bad_cnt + 32'(bad_inc);
      end
endmodule

// File: tb/tb_pkt_rx_check.sv
// tb_pkt_rx_check: scoreboard bench for the upload packet checker
module tb_pkt_rx_check;
   localparam int          YUZHI  = 128;
   localparam logic [31:0] HEAD   = 32'hadf90c00;
   localparam int          NUM_CH = 30;
   typedef struct {logic [63:0] d; logic [4:0] c; logic l;} pay_t;
   logic clk = 1'b0;
   logic rst_n;
   pkt_rx_check_if bus ();
   pkt_rx_check #(.YUZHI(YUZHI), .HEAD(HEAD), .NUM_CH(NUM_CH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   pay_t        pay_q [$];
   logic [4:0]  rep_q [$];
   logic [63:0] mexp [0:31];
   int          mgood, mbad, n_chk, n_err;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic drive(input logic [63:0] d, input logic v);
      bus.data_valid = v;
      bus.up_data    = d;
      @(posedge clk);
      #1;
   endtask
   task automatic pkt(input logic [31:0] hd, input logic [31:0] ch, input logic [63:0] sq, input int np, input int gap);
      logic hb, cb, se, ln;
      logic [63:0] base;
      hb   = hd != HEAD;
      cb   = ch == 0 || ch > NUM_CH;
      se   = 1'b0;
      ln   = 1'b0;
      base = {ch[15:0], sq[15:0], 32'h0};
      if (!(hb || cb)) begin
         se = sq != mexp[ch[4:0]] + 64'd1;
         mexp[ch[4:0]] = sq;
         ln = np != YUZHI;
         for (int i = 0; i < np && i < YUZHI; i++) pay_q.push_back('{base + 64'(i), ch[4:0], i == YUZHI - 1});
      end
      if (hb || cb || se || ln) mbad++;
      else mgood++;
      rep_q.push_back({~(hb | cb | se | ln), hb, cb, se, ln});
      drive({hd, ch}, 1'b1);
      drive(sq, 1'b1);
      for (int i = 0; i < np; i++) drive(base + 64'(i), 1'b1);
      for (int i = 0; i < gap; i++) drive('0, 1'b0);
   endtask
   task automatic settle(input string tag);
      repeat (3) drive('0, 1'b0);
      check({tag, "_good"}, bus.good_cnt, 64'(mgood));
      check({tag, "_bad"}, bus.bad_cnt, 64'(mbad));
   endtask
   // scoreboard: pop expectations as the DUT produces payload words and reports
   always @(negedge clk) if (rst_n) begin
      if (bus.pay_valid) begin
         if (pay_q.size() == 0) check("pay_extra", 64'd1, 64'd0);
         else begin
            pay_t e;
            e = pay_q.pop_front();
            check("pay_data", bus.pay_data, e.d);
            check("pay_chan", 64'(bus.pay_chan), 64'(e.c));
            check("pay_last", 64'(bus.pay_last), 64'(e.l));
         end
      end else if (bus.pay_last) check("pay_last_idle", 64'(bus.pay_last), 64'd0);
      if (bus.pkt_done) begin
         if (rep_q.size() == 0) check("rep_extra", 64'd1, 64'd0);
         else check("report", 64'({bus.pkt_ok, bus.err_head, bus.err_chan, bus.err_seq, bus.err_len}), 64'(rep_q.pop_front()));
      end else if ({bus.pkt_ok, bus.err_head, bus.err_chan, bus.err_seq, bus.err_len} != 5'd0)
         check("flags_idle", 64'({bus.pkt_ok, bus.err_head, bus.err_chan, bus.err_seq, bus.err_len}), 64'd0);
   end
   initial begin
      for (int i = 0; i < 32; i++) mexp[i] = '0;
      rst_n = 1'b0;
      bus.data_valid = 1'b0;
      bus.up_data = '0;
      #1;
      check("rst_pay_valid", 64'(bus.pay_valid), 64'd0);
      check("rst_pkt_done", 64'(bus.pkt_done), 64'd0);
      check("rst_flags", 64'({bus.pkt_ok, bus.err_head, bus.err_chan, bus.err_seq, bus.err_len}), 64'd0);
      check("rst_good", bus.good_cnt, 64'd0);
      check("rst_bad", bus.bad_cnt, 64'd0);
      #20 rst_n = 1'b1;
      @(posedge clk);
      #1;
      pkt(HEAD, 5, 1, 128, 2);
      settle("t1");
      pkt(HEAD, 5, 3, 128, 2);
      pkt(HEAD, 5, 4, 128, 2);
      settle("t2");
      pkt(32'h12345678, 5, 5, 128, 2);
      pkt(HEAD, 0, 1, 4, 2);
      pkt(HEAD, 31, 1, 4, 2);
      settle("t3");
      pkt(HEAD, 5, 5, 50, 2);
      pkt(HEAD, 5, 6, 129, 2);
      settle("t4");
      pkt(HEAD, 1, 1, 128, 2);
      pkt(HEAD, 30, 1, 128, 2);
      pkt(HEAD, 1, 2, 128, 2);
      pkt(HEAD, 30, 2, 128, 2);
      settle("t5");
      pkt(HEAD, 7, 1, 128, 1);
      drive(64'hdead_beef, 1'b1);
      mbad++;
      settle("viol");
      drive({HEAD, 32'd5}, 1'b1);
      drive(64'd7, 1'b1);
      for (int i = 0; i < 60; i++) begin
         pay_q.push_back('{64'(i) + 64'h55, 5'd5, 1'b0});
         drive(64'(i) + 64'h55, 1'b1);
      end
      @(negedge clk);
      #1;
      bus.data_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("t6_pay_valid", 64'(bus.pay_valid), 64'd0);
      check("t6_good", bus.good_cnt, 64'd0);
      check("t6_bad", bus.bad_cnt, 64'd0);
      for (int i = 0; i < 32; i++) mexp[i] = '0;
      mgood = 0;
      mbad = 0;
      #13 rst_n = 1'b1;
      @(posedge clk);
      #1;
      pkt(HEAD, 5, 1, 128, 2);
      settle("t6");
      check("pay_left", 64'(pay_q.size()), 64'd0);
      check("rep_left", 64'(rep_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
